// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared types and constants for the capture scheduler
//
// Purpose: FSM state encoding, record header default, control word bit
// positions and the record-size helper shared by capture_sched.
package capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_ADVANCE = 3'd4
    } capture_sched_state_t;

    localparam int HDR_BYTES_DEFAULT = 16;

    localparam int CTRL_VALID_BIT = 0;
    localparam int CTRL_WRAP_BIT  = 1;

    // Header plus payload, rounded up to the next 4-byte boundary.
    function automatic logic [31:0] record_bytes(input logic [31:0] len,
                                                 input logic [31:0] hdr);
        logic [31:0] raw;
        raw = hdr + len + 32'd3;
        return {raw[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/desc_fifo.sv
// rtl/desc_fifo.sv - synchronous descriptor FIFO with full/empty flags
//
// Purpose: holds {end, begin} descriptor pairs between the capture front
// end and the scheduler FSM. Head entry is visible on pop_data while
// not empty (show-ahead); pop advances it.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   push, push_data write request and data
//   pop, pop_data   read request and current head entry
//   full, empty     occupancy flags
module desc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    // A full queue still accepts a write when the head leaves in the same cycle.
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (pop_ok) begin
                rd_idx <= rd_idx + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/capture_sched.sv
// rtl/capture_sched.sv - packet-capture ring scheduler driving the DMA writer
//
// Purpose: queues packet descriptors, sizes each capture record, places it
// in the host ring (wrapping to offset 0 when it would cross the ring end),
// starts one writer transfer at a time and advances the write pointer
// against the host read pointer.
// Build option: CAPTURE_SCHED_DROP_EN - when defined, a record that does not
// fit is dropped; otherwise CHECK waits for the host to free space.
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   enable                           allow new records to start
//   ring_base, ring_size, host_rd_ptr ring geometry and host consumption
//   desc_valid/desc_ready/desc_begin/desc_end  descriptor input
//   wr_ctrl, control, pkt_begin, pkt_end, write_address  writer command
//   wr_ctrl_rdy                      writer done pulse
//   wr_ptr, pkt_count, drop_count, busy, irq  status to CSR block
module capture_sched
    import capture_pkg::*;
#(
    parameter int DESC_DEPTH = 4,
    parameter int HDR_BYTES  = HDR_BYTES_DEFAULT,
    parameter int MAX_PKT    = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] ring_base,
    input  logic [31:0] ring_size,
    input  logic [31:0] host_rd_ptr,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [31:0] desc_begin,
    input  logic [31:0] desc_end,
    output logic        wr_ctrl,
    output logic [31:0] control,
    output logic [31:0] pkt_begin,
    output logic [31:0] pkt_end,
    output logic [31:0] write_address,
    input  logic        wr_ctrl_rdy,
    output logic [31:0] wr_ptr,
    output logic [31:0] pkt_count,
    output logic [31:0] drop_count,
    output logic        busy,
    output logic        irq
);

`ifdef CAPTURE_SCHED_DROP_EN
    localparam bit NO_SPACE_DROP = 1'b1;
`else
    localparam bit NO_SPACE_DROP = 1'b0;
`endif

    capture_sched_state_t state, state_nxt;

    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    logic [63:0] fifo_head;

    logic [31:0] len;
    logic [31:0] rec;
    logic [31:0] free;
    logic [31:0] need;
    logic [31:0] off;
    logic [31:0] ctrl_nxt;
    logic        bad;
    logic        wrap;
    logic        fits;
    logic        drop;

    logic [31:0] off_q;
    logic [31:0] rec_q;
    logic [31:0] adv_ptr;

    assign desc_ready = !fifo_full;
    assign fifo_push  = desc_valid && desc_ready;
    assign fifo_pop   = (state == ST_IDLE) && enable && !fifo_empty;

    desc_fifo #(
        .DEPTH (DESC_DEPTH),
        .WIDTH (64)
    ) u_desc_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({desc_end, desc_begin}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Placement arithmetic for the latched descriptor, evaluated live in CHECK
    // so a stalled record sees host_rd_ptr move.
    always_comb begin
        len  = pkt_end - pkt_begin;
        rec  = record_bytes(len, 32'(HDR_BYTES));
        bad  = (pkt_end <= pkt_begin) || (len > 32'(MAX_PKT));
        wrap = (wr_ptr + rec) > ring_size;
        off  = wrap ? 32'd0 : wr_ptr;
        // The 4-byte reserve keeps a full ring distinguishable from an empty one.
        if (host_rd_ptr > wr_ptr) begin
            free = host_rd_ptr - wr_ptr - 32'd4;
        end else begin
            free = ring_size - wr_ptr + host_rd_ptr - 32'd4;
        end
        // Wrapping also consumes the unused tail of the ring.
        need = rec + (wrap ? (ring_size - wr_ptr) : 32'd0);
        fits = !bad && (need <= free);
        drop = (state == ST_CHECK) && (bad || (NO_SPACE_DROP && !fits));
        ctrl_nxt = '0;
        ctrl_nxt[CTRL_VALID_BIT] = 1'b1;
        ctrl_nxt[CTRL_WRAP_BIT]  = wrap;
        adv_ptr = off_q + rec_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (bad) begin
                    state_nxt = ST_IDLE;
                end else if (fits) begin
                    state_nxt = ST_ISSUE;
                end else if (NO_SPACE_DROP) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (wr_ctrl_rdy) begin
                    state_nxt = ST_ADVANCE;
                end
            end
            ST_ADVANCE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ctrl = (state == ST_ISSUE);
        irq     = (state == ST_ADVANCE);
        busy    = (state != ST_IDLE);
    end

    // Datapath registers. wr_ptr and pkt_count move on the WAIT->ADVANCE edge
    // so they are already updated in the cycle irq is raised.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_begin     <= '0;
            pkt_end       <= '0;
            control       <= '0;
            write_address <= '0;
            off_q         <= '0;
            rec_q         <= '0;
            wr_ptr        <= '0;
            pkt_count     <= '0;
            drop_count    <= '0;
        end else begin
            if (fifo_pop) begin
                pkt_begin <= fifo_head[31:0];
                pkt_end   <= fifo_head[63:32];
            end
            if ((state == ST_CHECK) && fits) begin
                off_q         <= off;
                rec_q         <= rec;
                control       <= ctrl_nxt;
                write_address <= ring_base + off;
            end
            if (drop) begin
                drop_count <= drop_count + 32'd1;
            end
            if ((state == ST_WAIT) && wr_ctrl_rdy) begin
                wr_ptr    <= (adv_ptr == ring_size) ? 32'd0 : adv_ptr;
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_capture_sched.sv
// tb/tb_capture_sched.sv - directed scoreboard bench for capture_sched
module tb_capture_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] ring_base = 32'h1000_0000;
    logic [31:0] ring_size = 32'd256;
    logic [31:0] host_rd_ptr = '0;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [31:0] desc_begin = '0;
    logic [31:0] desc_end = '0;
    logic        wr_ctrl;
    logic [31:0] control;
    logic [31:0] pkt_begin;
    logic [31:0] pkt_end;
    logic [31:0] write_address;
    logic        wr_ctrl_rdy = 1'b0;
    logic [31:0] wr_ptr;
    logic [31:0] pkt_count;
    logic [31:0] drop_count;
    logic        busy;
    logic        irq;

    capture_sched dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .ring_base     (ring_base),
        .ring_size     (ring_size),
        .host_rd_ptr   (host_rd_ptr),
        .desc_valid    (desc_valid),
        .desc_ready    (desc_ready),
        .desc_begin    (desc_begin),
        .desc_end      (desc_end),
        .wr_ctrl       (wr_ctrl),
        .control       (control),
        .pkt_begin     (pkt_begin),
        .pkt_end       (pkt_end),
        .write_address (write_address),
        .wr_ctrl_rdy   (wr_ctrl_rdy),
        .wr_ptr        (wr_ptr),
        .pkt_count     (pkt_count),
        .drop_count    (drop_count),
        .busy          (busy),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ctrl;
        logic [31:0] b;
        logic [31:0] e;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   failures = 0;
    int   wr_cnt = 0;
    int   snap;

    always @(posedge clk) begin
        if (reset && wr_ctrl === 1'b1) begin
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wr_ctrl"}, {31'd0, wr_ctrl}, 32'd0);
        check({tag, "_control"}, control, 32'd0);
        check({tag, "_pkt_begin"}, pkt_begin, 32'd0);
        check({tag, "_pkt_end"}, pkt_end, 32'd0);
        check({tag, "_write_address"}, write_address, 32'd0);
        check({tag, "_wr_ptr"}, wr_ptr, 32'd0);
        check({tag, "_pkt_count"}, pkt_count, 32'd0);
        check({tag, "_drop_count"}, drop_count, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_irq"}, {31'd0, irq}, 32'd0);
        check({tag, "_desc_ready"}, {31'd0, desc_ready}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        enable = 1'b0;
        desc_valid = 1'b0;
        wr_ctrl_rdy = 1'b0;
        host_rd_ptr = '0;
        sb.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        enable = 1'b1;
    endtask

    task automatic push_desc(input logic [31:0] b, input logic [31:0] e);
        desc_valid = 1'b1;
        desc_begin = b;
        desc_end = e;
        tick();
        desc_valid = 1'b0;
    endtask

    task automatic expect_rec(input logic [31:0] off, input logic [31:0] ctrl,
                              input logic [31:0] b, input logic [31:0] e);
        exp_t x;
        x.addr = 32'h1000_0000 + off;
        x.ctrl = ctrl;
        x.b = b;
        x.e = e;
        sb.push_back(x);
    endtask

    // Wait for the writer start, compare it against the scoreboard head,
    // hold WAIT for a while, then return the done pulse and check the commit.
    task automatic serve(input string tag, input logic [31:0] exp_ptr);
        int   n;
        exp_t x;
        n = 0;
        while (wr_ctrl !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_issue"}, {31'd0, wr_ctrl}, 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            x = sb.pop_front();
            check({tag, "_addr"}, write_address, x.addr);
            check({tag, "_ctrl"}, control, x.ctrl);
            check({tag, "_begin"}, pkt_begin, x.b);
            check({tag, "_end"}, pkt_end, x.e);
        end
        tick();
        tick();
        check({tag, "_wait_no_start"}, {31'd0, wr_ctrl}, 32'd0);
        check({tag, "_wait_busy"}, {31'd0, busy}, 32'd1);
        wr_ctrl_rdy = 1'b1;
        tick();
        wr_ctrl_rdy = 1'b0;
        check({tag, "_irq"}, {31'd0, irq}, 32'd1);
        check({tag, "_wr_ptr"}, wr_ptr, exp_ptr);
        tick();
        check({tag, "_irq_clear"}, {31'd0, irq}, 32'd0);
    endtask

    initial begin
        // Reset state, sampled while reset is held.
        tick();
        check_idle_outputs("reset");
        reset = 1'b1;
        tick();
        enable = 1'b1;

        // Single record with exact start latency.
        host_rd_ptr = 32'd0;
        expect_rec(32'd0, 32'h1, 32'h100, 32'h13C);
        push_desc(32'h100, 32'h13C);
        tick();
        check("single_n2_no_start", {31'd0, wr_ctrl}, 32'd0);
        tick();
        check("single_n3_start", {31'd0, wr_ctrl}, 32'd1);
        serve("single", 32'd76);
        check("single_pkt_count", pkt_count, 32'd1);

        // Rounding: 16 + 61 = 77 -> 80.
        do_reset();
        expect_rec(32'd0, 32'h1, 32'd0, 32'd61);
        push_desc(32'd0, 32'd61);
        serve("round", 32'd80);

        // Wrap: fill to 200 with two 100-byte records, then host frees to 100.
        do_reset();
        expect_rec(32'd0, 32'h1, 32'h0, 32'd84);
        push_desc(32'h0, 32'd84);
        serve("fill1", 32'd100);
        expect_rec(32'd100, 32'h1, 32'h200, 32'h254);
        push_desc(32'h200, 32'h254);
        serve("fill2", 32'd200);
        host_rd_ptr = 32'd100;
        expect_rec(32'd0, 32'h3, 32'h300, 32'h33C);
        push_desc(32'h300, 32'h33C);
        serve("wrap", 32'd76);
        check("wrap_pkt_count", pkt_count, 32'd3);

        // No space: wr_ptr=200, rd=210 leaves 6 bytes free.
        do_reset();
        expect_rec(32'd0, 32'h1, 32'h0, 32'd84);
        push_desc(32'h0, 32'd84);
        serve("ns_fill1", 32'd100);
        expect_rec(32'd100, 32'h1, 32'h200, 32'h254);
        push_desc(32'h200, 32'h254);
        serve("ns_fill2", 32'd200);
        host_rd_ptr = 32'd210;
        snap = wr_cnt;
`ifdef CAPTURE_SCHED_DROP_EN
        push_desc(32'h400, 32'h43C);
        repeat (8) tick();
        check("nospace_drop_count", drop_count, 32'd1);
        check("nospace_no_start", 32'(wr_cnt - snap), 32'd0);
        check("nospace_idle", {31'd0, busy}, 32'd0);
`else
        expect_rec(32'd0, 32'h3, 32'h400, 32'h43C);
        push_desc(32'h400, 32'h43C);
        repeat (10) tick();
        check("nospace_stall_no_start", 32'(wr_cnt - snap), 32'd0);
        check("nospace_stall_busy", {31'd0, busy}, 32'd1);
        check("nospace_stall_drop", drop_count, 32'd0);
        // Host frees up to offset 100: 56 + 100 - 4 = 152 >= 76 + 56.
        host_rd_ptr = 32'd100;
        serve("nospace_release", 32'd76);
`endif

        // Invalid descriptors: empty and oversized.
        do_reset();
        snap = wr_cnt;
        push_desc(32'h80, 32'h80);
        push_desc(32'd0, 32'd4000);
        repeat (8) tick();
        check("invalid_drop_count", drop_count, 32'd2);
        check("invalid_no_start", 32'(wr_cnt - snap), 32'd0);
        check("invalid_pkt_count", pkt_count, 32'd0);

        // Back-pressure: queue four 16-byte packets while disabled.
        do_reset();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_ready_%0d", i), {31'd0, desc_ready}, (i < 4) ? 32'd1 : 32'd0);
            if (i < 4) begin
                expect_rec(32'(i * 32), 32'h1, 32'(i * 64), 32'(i * 64 + 16));
            end
            push_desc(32'(i * 64), 32'(i * 64 + 16));
        end
        check("bp_ready_full", {31'd0, desc_ready}, 32'd0);
        check("bp_idle_disabled", {31'd0, busy}, 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve($sformatf("bp_rec%0d", i), 32'((i + 1) * 32));
        end
        check("bp_pkt_count", pkt_count, 32'd4);
        check("bp_sb_drained", 32'(sb.size()), 32'd0);

        // Reset while the writer is busy, with one more descriptor queued.
        push_desc(32'h800, 32'h83C);
        push_desc(32'h900, 32'h93C);
        for (int n = 0; n < 20 && wr_ctrl !== 1'b1; n++) begin
            tick();
        end
        check("rst_issue_seen", {31'd0, wr_ctrl}, 32'd1);
        tick();
        reset = 1'b0;
        #1;
        check_idle_outputs("midrst");
        tick();
        reset = 1'b1;
        snap = wr_cnt;
        repeat (8) tick();
        check("midrst_queue_empty", 32'(wr_cnt - snap), 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
